// File: rtl/out_serializer_pkg.sv
// Shared defaults, FSM encoding and derived widths
// for the word-to-byte output serializer.
package out_serializer_pkg;

   localparam int N_DEF     = 64;
   localparam int W_DEF     = 8;
   localparam int DEPTH_DEF = 4;
   localparam int BPW_DEF   = N_DEF / W_DEF;
   localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/out_serializer_fifo.sv
// Word FIFO in front of the serializer; registered count,
// head word presented on dout while count is non-zero.
module out_fifo
   import out_serializer_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [N-1:0]     din_i,
   output logic [N-1:0]     dout_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [N-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] count_q;

   // Storage has no reset; only pointers/count define validity.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/out_serializer.sv
// Captures result words into a FIFO and streams them out
// LSB-byte first over a valid/ready byte handshake.
module out_serializer
   import out_serializer_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         word_valid,
   input  logic [N-1:0] word_in,
   output logic [W-1:0] byte_out,
   output logic         byte_valid,
   input  logic         byte_ready,
   output logic         full,
   output logic         overflow,
   output logic         busy
);

   localparam int BPW   = N / W;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   state_e           state_q, state_d;
   logic [N-1:0]     sh_q, sh_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic             full_q, full_d;

   logic             fire, last, nempty, pop, push;
   logic [N-1:0]     head;
   logic [CNT_W-1:0] count;

   out_fifo #(
      .N     (N),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (word_in),
      .dout_o  (head),
      .count_o (count)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      idx_d   = idx_q;
      fire    = (state_q == SEND) && byte_ready;
      last    = fire && (idx_q == IDX_W'(BPW - 1));
      nempty  = (count != '0);
      // Pop decisions use the pre-write count: no fallthrough.
      pop     = nempty && ((state_q == IDLE) || last);
      push    = word_valid && ((count != CNT_W'(DEPTH)) || pop);
      ovf_d   = ovf_q || (word_valid && !push);
      full_d  = (count + CNT_W'(push) - CNT_W'(pop))
                == CNT_W'(DEPTH);
      if (pop) begin
         sh_d    = head;
         idx_d   = '0;
         state_d = SEND;
      end else if (last) begin
         state_d = IDLE;
      end else if (fire) begin
         sh_d  = sh_q >> W;
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         full_q  <= full_d;
      end
   end

   assign byte_out   = sh_q[W-1:0];
   assign byte_valid = (state_q == SEND);
   assign full       = full_q;
   assign overflow   = ovf_q;
   assign busy       = nempty || (state_q == SEND);

endmodule
